mb_scan_controller: RTL and testbench
=====================================

// Module: mb_scan_controller
// PURPOSE
//  Frame-level macroblock sequencer for the encoder datapath; successor to the start/stop hold FSM.
//  Walks a WIDTH x HEIGHT frame in raster order, 16x16 macroblocks, and offers one MB coordinate
//  per valid/ready handshake. Adds graceful stop, single/continuous frame mode, first/last flags
//  and a frame counter. Sits between top-level control and the MB fetch/intra-prediction stages.
// PARAMETERS
//  WIDTH        352  frame width in pixels; must be a multiple of MB_SIZE
//  HEIGHT       288  frame height in pixels; must be a multiple of MB_SIZE
//  MB_SIZE      16   macroblock edge in pixels
//  FRAME_CNT_W  8    width of frame counter
//  (derived) MBW=WIDTH/MB_SIZE, MBH=HEIGHT/MB_SIZE, XW=max(1,$clog2(MBW)), YW=max(1,$clog2(MBH))
// PORTS
//  clk         in   1            clock, rising edge
//  rst         in   1            reset, asynchronous, active-low
//  start       in   1            begin a frame (sampled in IDLE only)
//  stop        in   1            request stop at next MB boundary
//  continuous  in   1            1: loop frames until stop; 0: one frame then IDLE
//  mb_ready    in   1            downstream accepts the current MB
//  mb_valid    out  1            mb_x/mb_y/flags are valid
//  mb_x        out  XW           MB column, 0..MBW-1
//  mb_y        out  YW           MB row, 0..MBH-1
//  mb_first    out  1            current MB is (0,0)
//  mb_last     out  1            current MB is (MBW-1,MBH-1)
//  frame_done  out  1            one-cycle pulse after the last MB of a frame is accepted
//  frame_cnt   out  FRAME_CNT_W  frames completed since reset; wraps modulo 2^FRAME_CNT_W
//  hold        out  1            1 while IDLE (downstream stall, same meaning as previous controller)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, mb_x=0, mb_y=0, mb_valid=0, hold=1, frame_done=0, frame_cnt=0.
//  States: IDLE, RUN, STOP. All outputs are registered or decoded from registered state/counters only.
//  mb_valid=1 in RUN and STOP; hold=1 only in IDLE; mb_first/mb_last decoded from mb_x/mb_y.
//  Handshake: MB accepted on cycle where mb_valid&mb_ready. mb_x/mb_y held stable until accepted.
//  IDLE: start=1 & stop=0 -> RUN; mb_valid=1 from next cycle with (0,0). start&stop -> stay IDLE.
//  RUN, on acceptance: mb_x++; at mb_x=MBW-1, mb_x<=0 and mb_y++.
//  Acceptance of last MB: frame_done=1 next cycle, frame_cnt++, mb_x=mb_y=0;
//    continuous=1 & stop=0 -> stay RUN, next frame starts with no bubble; else -> IDLE.
//  RUN, stop=1: if acceptance same cycle -> IDLE (last-MB bookkeeping still applies);
//    else -> STOP. STOP keeps mb_valid=1 with same coordinate until accepted, then -> IDLE.
//  Entering IDLE by stop mid-frame: mb_x=mb_y=0, frame_cnt unchanged, frame_done not pulsed.
//  start while RUN/STOP ignored; stop while IDLE ignored; continuous sampled only at frame end.
//  Reset asserted mid-frame: immediate return to reset values, no partial frame_done.
//  Degenerate MBW=1 or MBH=1 valid: wrap logic handles single-column/row frames; 1x1 frame
//    asserts mb_first and mb_last together.
// TESTING  (bench uses WIDTH=48, HEIGHT=32 -> MBW=3, MBH=2 unless stated)
//  1 rst low mid-RUN at (2,1) -> next sample: mb_valid=0, hold=1, mb_x=0, mb_y=0, frame_cnt=0.
//  2 start pulse, continuous=0, mb_ready=1 -> (0,0)(1,0)(2,0)(0,1)(1,1)(2,1) on 6 cycles,
//    mb_first on 1st, mb_last on 6th, frame_done 1 cycle after, frame_cnt=1, hold=1.
//  3 mb_ready toggled 0/1 randomly -> coordinates stable while mb_ready=0; sequence identical to 2.
//  4 continuous=1, ready=1 -> 3 frames back-to-back with no idle cycle; frame_done 3 pulses,
//    frame_cnt=3; stop then asserted -> IDLE after current MB accepted.
//  5 stop at (1,0) with mb_ready=0 for 4 cycles -> STOP, (1,0) held 4 cycles, accepted, then IDLE,
//    no frame_done, frame_cnt unchanged; start+stop same cycle in IDLE -> stays IDLE.
//  6 FRAME_CNT_W=2, 5 continuous frames -> frame_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/mb_scan_controller.sv
// Raster-order macroblock sequencer: offers one MB coordinate per valid/ready handshake,
// with single/continuous frame mode, graceful stop, first/last flags and a frame counter.
module mb_scan_controller #(
    parameter  int WIDTH       = 352,
    parameter  int HEIGHT      = 288,
    parameter  int MB_SIZE     = 16,
    parameter  int FRAME_CNT_W = 8,
    localparam int MBW         = WIDTH / MB_SIZE,
    localparam int MBH         = HEIGHT / MB_SIZE,
    localparam int XW          = (MBW > 1) ? $clog2(MBW) : 1,
    localparam int YW          = (MBH > 1) ? $clog2(MBH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic                   mb_ready,
    output logic                   mb_valid,
    output logic [XW-1:0]          mb_x,
    output logic [YW-1:0]          mb_y,
    output logic                   mb_first,
    output logic                   mb_last,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   hold
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP
    } state_e;

    localparam logic [XW-1:0] X_LAST = XW'(MBW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MBH - 1);

    state_e                 state_q;
    logic [XW-1:0]          mb_x_q, mb_x_d;
    logic [YW-1:0]          mb_y_q, mb_y_d;
    logic                   mb_valid_q;
    logic                   hold_q;
    logic                   frame_done_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic accept;
    logic x_at_end;
    logic last_mb;

    assign accept   = mb_valid_q & mb_ready;
    assign x_at_end = (mb_x_q == X_LAST);
    assign last_mb  = x_at_end & (mb_y_q == Y_LAST);

    // Raster advance; single-column frames wrap every MB because x_at_end is always true.
    always_comb begin
        mb_x_d = mb_x_q + XW'(1);
        mb_y_d = mb_y_q;
        if (x_at_end) begin
            mb_x_d = '0;
            mb_y_d = mb_y_q + YW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            mb_valid_q   <= 1'b0;
            hold_q       <= 1'b1;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q    <= S_RUN;
                        mb_valid_q <= 1'b1;
                        hold_q     <= 1'b0;
                    end
                end
                S_RUN, S_STOP: begin
                    if (accept) begin
                        if (last_mb) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
                            mb_x_q       <= '0;
                            mb_y_q       <= '0;
                            // Only an uninterrupted continuous run rolls into the next frame.
                            if (!(state_q == S_RUN && continuous && !stop)) begin
                                state_q    <= S_IDLE;
                                mb_valid_q <= 1'b0;
                                hold_q     <= 1'b1;
                            end
                        end else if (state_q == S_STOP || stop) begin
                            state_q    <= S_IDLE;
                            mb_valid_q <= 1'b0;
                            hold_q     <= 1'b1;
                            mb_x_q     <= '0;
                            mb_y_q     <= '0;
                        end else begin
                            mb_x_q <= mb_x_d;
                            mb_y_q <= mb_y_d;
                        end
                    end else if (stop && state_q == S_RUN) begin
                        state_q <= S_STOP;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    mb_valid_q <= 1'b0;
                    hold_q     <= 1'b1;
                    mb_x_q     <= '0;
                    mb_y_q     <= '0;
                end
            endcase
        end
    end

    assign mb_valid   = mb_valid_q;
    assign mb_x       = mb_x_q;
    assign mb_y       = mb_y_q;
    assign mb_first   = (mb_x_q == '0) && (mb_y_q == '0);
    assign mb_last    = last_mb;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign hold       = hold_q;

endmodule

// File: tb/tb_mb_scan_controller.sv
// Scoreboard bench for mb_scan_controller on a 3x2 MB frame, plus a 2-bit counter instance.
module tb_mb_scan_controller;

    localparam int WIDTH  = 48;
    localparam int HEIGHT = 32;
    localparam int MBW    = 3;
    localparam int MBH    = 2;
    localparam int XW     = 2;
    localparam int YW     = 1;
    localparam int FCW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, continuous = 1'b0, mb_ready = 1'b0;
    logic mb_valid, mb_first, mb_last, frame_done, hold;
    logic [XW-1:0]  mb_x;
    logic [YW-1:0]  mb_y;
    logic [FCW-1:0] frame_cnt;

    logic start2 = 1'b0, stop2 = 1'b0, continuous2 = 1'b0, mb_ready2 = 1'b0;
    logic mb_valid2, mb_first2, mb_last2, frame_done2, hold2;
    logic [XW-1:0] mb_x2;
    logic [YW-1:0] mb_y2;
    logic [1:0]    frame_cnt2;

    always #5 clk = ~clk;

    mb_scan_controller #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MB_SIZE(16), .FRAME_CNT_W(FCW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .mb_ready(mb_ready), .mb_valid(mb_valid), .mb_x(mb_x), .mb_y(mb_y),
        .mb_first(mb_first), .mb_last(mb_last), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .hold(hold)
    );

    mb_scan_controller #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MB_SIZE(16), .FRAME_CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .continuous(continuous2),
        .mb_ready(mb_ready2), .mb_valid(mb_valid2), .mb_x(mb_x2), .mb_y(mb_y2),
        .mb_first(mb_first2), .mb_last(mb_last2), .frame_done(frame_done2),
        .frame_cnt(frame_cnt2), .hold(hold2)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          first;
        logic          last;
    } mb_t;

    mb_t sb[$];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  exp_cnt   = 0;
    int  done_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_mb(input int x, input int y);
        mb_t e;
        e.x     = XW'(x);
        e.y     = YW'(y);
        e.first = (x == 0) && (y == 0);
        e.last  = (x == MBW - 1) && (y == MBH - 1);
        sb.push_back(e);
    endtask

    task automatic push_frame();
        for (int y = 0; y < MBH; y++)
            for (int x = 0; x < MBW; x++)
                push_mb(x, y);
    endtask

    // Drive one cycle from a negedge; score any acceptance, then check post-edge outputs.
    task automatic cycle(input logic rdy, input logic st, input logic sp, input logic ct);
        mb_t  e;
        logic pend_done = 1'b0;
        logic held;
        int   px, py;
        start = st; stop = sp; continuous = ct; mb_ready = rdy;
        held = mb_valid && !rdy;
        px = int'(mb_x);
        py = int'(mb_y);
        if (mb_valid && rdy) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("mb_x", int'(mb_x), int'(e.x));
                check("mb_y", int'(mb_y), int'(e.y));
                check("mb_first", int'(mb_first), int'(e.first));
                check("mb_last", int'(mb_last), int'(e.last));
                pend_done = e.last;
            end
        end
        @(negedge clk);
        if (frame_done) done_seen++;
        if (pend_done) exp_cnt++;
        check("frame_done", int'(frame_done), int'(pend_done));
        check("frame_cnt", int'(frame_cnt), exp_cnt % (1 << FCW));
        if (held) begin
            check("held_valid", int'(mb_valid), 1);
            check("held_x", int'(mb_x), px);
            check("held_y", int'(mb_y), py);
        end
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(mb_valid), 0);
        check("rst_hold", int'(hold), 1);
        check("rst_x", int'(mb_x), 0);
        check("rst_y", int'(mb_y), 0);
        check("rst_fcnt", int'(frame_cnt), 0);
        check("rst_done", int'(frame_done), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single frame, ready always high.
        push_frame();
        cycle(1, 1, 0, 0);
        check("t2_valid", int'(mb_valid), 1);
        check("t2_hold", int'(hold), 0);
        for (int i = 0; i < MBW * MBH; i++) cycle(1, 0, 0, 0);
        check("t2_idle_valid", int'(mb_valid), 0);
        check("t2_idle_hold", int'(hold), 1);
        check("t2_fcnt", int'(frame_cnt), 1);

        // Single frame with random backpressure.
        push_frame();
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 200 && sb.size() > 0; i++) cycle(1'($urandom_range(0, 1)), 0, 0, 0);
        check("t3_drain", sb.size(), 0);
        check("t3_idle_valid", int'(mb_valid), 0);
        check("t3_fcnt", int'(frame_cnt), 2);

        // Asynchronous reset while presenting (2,1).
        push_frame();
        cycle(1, 1, 0, 0);
        for (int i = 0; i < MBW * MBH - 1; i++) cycle(1, 0, 0, 0);
        check("t1_pre_x", int'(mb_x), 2);
        check("t1_pre_y", int'(mb_y), 1);
        rst = 1'b0;
        #2;
        check("t1_valid", int'(mb_valid), 0);
        check("t1_hold", int'(hold), 1);
        check("t1_x", int'(mb_x), 0);
        check("t1_y", int'(mb_y), 0);
        check("t1_fcnt", int'(frame_cnt), 0);
        check("t1_done", int'(frame_done), 0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        mb_ready = 1'b0;
        @(negedge clk);

        // Continuous: three back-to-back frames, then stop on the first MB of the fourth.
        base = done_seen;
        for (int f = 0; f < 3; f++) push_frame();
        push_mb(0, 0);
        cycle(1, 1, 0, 1);
        for (int i = 0; i < 3 * MBW * MBH; i++) begin
            cycle(1, 0, 0, 1);
            check("t4_no_bubble", int'(mb_valid), 1);
        end
        cycle(1, 0, 1, 1);
        check("t4_pulses", done_seen - base, 3);
        check("t4_idle_valid", int'(mb_valid), 0);
        check("t4_idle_hold", int'(hold), 1);
        check("t4_fcnt", int'(frame_cnt), 3);

        // Graceful stop at (1,0) under backpressure.
        base = done_seen;
        push_mb(0, 0);
        push_mb(1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("t5_stop_valid", int'(mb_valid), 1);
        check("t5_stop_hold", int'(hold), 0);
        check("t5_stop_x", int'(mb_x), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("t5_idle_valid", int'(mb_valid), 0);
        check("t5_idle_x", int'(mb_x), 0);
        check("t5_idle_y", int'(mb_y), 0);
        check("t5_fcnt", int'(frame_cnt), 3);
        check("t5_no_pulse", done_seen - base, 0);
        cycle(0, 1, 1, 0);
        check("t5_startstop_valid", int'(mb_valid), 0);
        check("t5_startstop_hold", int'(hold), 1);
        cycle(0, 0, 0, 0);
        check("t5_still_idle", int'(mb_valid), 0);

        // 2-bit frame counter over five continuous frames.
        start2 = 1'b1; continuous2 = 1'b1; mb_ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            if (f == 5) begin
                repeat (MBW * MBH - 1) @(negedge clk);
                stop2 = 1'b1;
                @(negedge clk);
            end else begin
                repeat (MBW * MBH) @(negedge clk);
            end
            check("t6_fcnt", int'(frame_cnt2), f % 4);
            check("t6_done", int'(frame_done2), 1);
        end
        check("t6_idle", int'(mb_valid2), 0);
        stop2 = 1'b0;

        check("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
